// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer and the
// instruction memory / cache.
//
// Handshake: imem_req high means a fetch of imem_addr is outstanding and the
// address stays stable until the memory answers. imem_rdy is a one-cycle
// strobe meaning imem_instr carries the data for that outstanding request.
// If imem_req is still high in the cycle after imem_rdy, that is a new request
// for whatever imem_addr now holds.
//
// Signals:
//   imem_req   sequencer -> memory  fetch request outstanding
//   imem_addr  sequencer -> memory  16-bit fetch address (halfword aligned)
//   imem_rdy   memory -> sequencer  response valid this cycle
//   imem_instr memory -> sequencer  16-bit instruction word
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_instr
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-PC owner and instruction fetch sequencer.
//
// Keeps the architectural fetch PC, issues requests to a variable-latency
// instruction memory, applies taken-branch redirects and hazard stalls,
// detects HLT, and drives the IF/ID pipeline register.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 hold IF/ID and PC this cycle
//   redirect, redirect_pc taken branch and its target (bit 0 ignored)
//   imem                  fetch bus (master side)
//   if_valid, if_instr,
//   if_pc_plus2           IF/ID register contents
//   halted                HLT fetched, fetching stopped
//   dbg_state             current FSM state (0 FETCH, 1 DISCARD, 2 HALT)
//
// Per-cycle priority is redirect > stall > imem_rdy.
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  pc_fetch_sequencer_if.master       imem,
  output logic                       if_valid,
  output logic [15:0]                if_instr,
  output logic [15:0]                if_pc_plus2,
  output logic                       halted,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,  // request for pc outstanding
    S_DISCARD = 2'd1,  // outstanding request is wrong-path; drop its data
    S_HALT    = 2'd2   // HLT delivered, no more requests
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] target_q, target_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_plus2_q, if_pc_plus2_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;

  // 16-bit adder, carry discarded: 16'hFFFE + 2 wraps to 16'h0000.
  assign pc_plus2     = pc_q + 16'd2;
  // Instructions are halfword aligned; the low target bit is forced to zero.
  assign redirect_tgt = {redirect_pc[15:1], 1'b0};

  // redirect_pc[0] is intentionally dropped by the alignment above.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      target_q      <= 16'h0000;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 16'h0000;
      if_pc_plus2_q <= 16'h0000;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    target_d      = target_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_plus2_d = if_pc_plus2_q;
    halted_d      = halted_q;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if (imem.imem_rdy) begin
            // Response for the old pc returns now: drop it and request the
            // target straight away.
            pc_d = redirect_tgt;
          end else begin
            // Address must stay stable while the wrong-path request is out.
            target_d = redirect_tgt;
            state_d  = S_DISCARD;
          end
        end else if (stall) begin
          // Hold IF/ID and pc; any response is dropped and pc re-requested.
        end else if (imem.imem_rdy) begin
          if_valid_d    = 1'b1;
          if_instr_d    = imem.imem_instr;
          if_pc_plus2_d = pc_plus2;
          if (imem.imem_instr[15:12] == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d = pc_plus2;
          end
        end else begin
          if_valid_d = 1'b0;
        end
      end

      S_DISCARD: begin
        // IF/ID already flushed on entry; it stays empty here.
        if_valid_d = 1'b0;
        if (redirect) begin
          target_d = redirect_tgt;
        end else if (imem.imem_rdy) begin
          // Wrong-path data returned and is dropped; the stall only concerns
          // IF/ID, so the pending redirect still takes effect.
          pc_d    = target_q;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        if (redirect) begin
          halted_d   = 1'b0;
          if_valid_d = 1'b0;
          pc_d       = redirect_tgt;
          state_d    = S_FETCH;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem.imem_req  = (state_q != S_HALT);
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc_plus2    = if_pc_plus2_q;
  assign halted         = halted_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the architectural fetch PC and sequences instruction fetch against a variable-latency instruction memory. It accepts taken-branch redirects from the decode-stage branch logic (B/BR target already resolved), honours hazard stalls, detects HLT, and drives the IF/ID pipeline register contents. It sits between the PC-control/branch-resolution logic and the instruction memory/cache.

Parameters:
RESET_PC, 16'h0000, fetch address after reset
HALT_OPCODE, 4'hF, instr[15:12] value identifying HLT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard stall from decode; holds IF/ID and PC
redirect  input  1  taken branch resolved this cycle; flush IF and refetch
redirect_pc  input  16  branch target (B immediate or BR register value)
imem_rdy  input  1  imem_instr valid for the outstanding request this cycle
imem_instr  input  16  instruction word from instruction memory
imem_req  output  1  fetch request outstanding; address must stay stable while high
imem_addr  output  16  fetch address
if_valid  output  1  IF/ID holds a valid instruction
if_instr  output  16  IF/ID instruction
if_pc_plus2  output  16  IF/ID PC+2 of if_instr
halted  output  1  HLT fetched; fetch stopped

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, imem_addr=RESET_PC, target=0, if_valid=0, if_instr=16'h0000, if_pc_plus2=16'h0000, halted=0. The in-flight request is abandoned; imem is reset with the core.
- imem_req is combinational: 1 in FETCH and DISCARD, 0 in HALT. imem_addr is registered and changes only when no request is outstanding or on imem_rdy.
- States: FETCH (request for pc outstanding), DISCARD (outstanding request is wrong-path; wait for it to return, then drop it), HALT.
- Priority per cycle: redirect > stall > imem_rdy.
- FETCH, redirect=1:
  - if_valid<=0 (flush).
  - If imem_rdy=1, the response is dropped; pc and imem_addr <= {redirect_pc[15:1],1'b0}; stay in FETCH.
  - If imem_rdy=0, target <= {redirect_pc[15:1],1'b0}; go to DISCARD with imem_addr held.
- FETCH, stall=1: if_* and pc hold. A response with imem_rdy=1 is dropped, and the same pc is re-requested next cycle.
- FETCH, imem_rdy=1, no stall/redirect:
  - if_instr<=imem_instr, if_pc_plus2<=pc+2, if_valid<=1.
  - If imem_instr[15:12]==HALT_OPCODE: go to HALT, halted<=1, pc holds the HLT address.
  - Otherwise pc and imem_addr <= pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- FETCH, imem_rdy=0, no stall/redirect: if_valid<=0 (bubble).
- DISCARD:
  - On imem_rdy the response is dropped; pc and imem_addr <= target; go to FETCH.
  - A new redirect overwrites target and keeps the state in DISCARD.
  - stall holds if_*; if_valid is already 0.
- HALT:
  - Fetch stops.
  - stall=1 holds the HLT in IF/ID; otherwise if_valid<=0 on the cycle after delivery.
  - redirect=1 (an older branch makes the HLT wrong-path): halted<=0, if_valid<=0, pc and imem_addr <= redirect target, go to FETCH.
  - The only other exit is reset.
- PC+2 uses a 16-bit adder; the carry-out is discarded.

Test Plan:
- Reset release, imem_rdy=1 every cycle, instrs 0x1000, 0x2000, 0x3000 -> imem_addr steps 0x0000, 0x0002, 0x0004; if_pc_plus2 steps 0x0002, 0x0004, 0x0006; if_valid=1 from the first cycle after reset.
- imem_rdy low for 3 cycles at addr 0x0004 -> imem_addr stays 0x0004 with imem_req=1; 3 bubbles (if_valid=0); then 0x0006 is fetched.
- Redirect to 0x0041 while a request for 0x0008 is pending (rdy=0) -> DISCARD; the 0x0008 data is dropped on rdy; next imem_addr=0x0040; no wrong-path if_valid.
- stall=1 for 2 cycles with imem_rdy=1 -> if_instr and if_pc_plus2 unchanged; pc re-requested; after stall drops, the next instruction follows with none skipped.
- Fetch 0xF000 at 0x0010 -> halted=1, imem_req=0, if_valid pulses once with if_pc_plus2=0x0012; a redirect to 0x0100 in HALT -> halted=0, fetch resumes at 0x0100.
- Start at pc=0xFFFE (RESET_PC=16'hFFFE) -> next imem_addr=0x0000; assert rst_n=0 mid-request -> outputs return to reset values immediately.
